// File: rtl/vending_pkg.sv
// Shared types and helpers for the parametrised vending machine: FSM states,
// coin values and price-table lookup.
package vending_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    COLLECT,
    VEND,
    REFUND
  } state_t;

  localparam logic [1:0] COIN1_VAL = 2'd1;
  localparam logic [1:0] COIN2_VAL = 2'd2;

  // Widest packed price table supported: 16 items x 16-bit prices.
  localparam int PRICE_TABLE_W = 256;

  function automatic int price_of(input logic [PRICE_TABLE_W-1:0] table_bits,
                                  input int idx, input int price_w);
    int p;
    p = 0;
    for (int b = 0; b < price_w; b++) begin
      if (table_bits[8'(idx * price_w + b)]) p = p | (1 << b);
    end
    return p;
  endfunction

endpackage

// File: rtl/vend_credit_acc.sv
// Credit register: saturating coin add, clear, and a compare against the current price.
// Latency: credit updates one cycle after add/clr; at_price is combinational from the register.
// Backpressure: none; add and clear are accepted every cycle (clear wins).
module vend_credit_acc #(
  parameter int CREDIT_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                add_en,
  input  logic [1:0]          add_val,
  input  logic [CREDIT_W-1:0] price,
  output logic [CREDIT_W-1:0] credit,
  output logic                at_price
);

  logic [CREDIT_W:0] sum;

  assign sum      = {1'b0, credit} + {{(CREDIT_W-1){1'b0}}, add_val};
  assign at_price = (credit >= price);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      credit <= '0;
    end else if (clr) begin
      credit <= '0;
    end else if (add_en) begin
      credit <= sum[CREDIT_W] ? {CREDIT_W{1'b1}} : sum[CREDIT_W-1:0];
    end
  end

endmodule

// File: rtl/vending_machine_param.sv
// Parametrised vending FSM: select, stock check, coin collection, vend with change or refund; VEND_TIMEOUT_EN adds idle auto-refund.
// Latency: outputs are registered from the state, so each pulse appears one cycle after its state (pdt two edges after the price is reached).
// Backpressure: none; inputs are single-cycle pulses and ignored outside the states that consume them.
module vending_machine_param
  import vending_pkg::*;
#(
  parameter int                         N_ITEMS  = 4,
  parameter int                         PRICE_W  = 4,
  parameter logic [N_ITEMS*PRICE_W-1:0] PRICES   = {4'd6, 4'd5, 4'd4, 4'd3},
  parameter int                         CREDIT_W = PRICE_W,
  parameter int                         TIMEOUT  = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       c1,
  input  logic                       c2,
  input  logic [N_ITEMS-1:0]         sel,
  input  logic                       cnl,
  input  logic [N_ITEMS-1:0]         item_available,
  output logic                       pdt,
  output logic [$clog2(N_ITEMS)-1:0] pdt_item,
  output logic [CREDIT_W-1:0]        cng,
  output logic [CREDIT_W-1:0]        rtn,
  output logic                       rtn_vld,
  output logic                       sold_out,
  output logic                       busy
);

  localparam int IDX_W = $clog2(N_ITEMS);

  state_t              state, state_nxt;
  logic [IDX_W-1:0]    idx, sel_idx;
  logic                sel_one;
  logic [CREDIT_W-1:0] price, credit;
  logic                at_price, credit_clr, coin_acc, tmo_expired;
  logic [1:0]          coin_val;

  assign sel_one = (sel != '0) && ((sel & (sel - 1'b1)) == '0);
  assign price   = CREDIT_W'(price_of(PRICE_TABLE_W'(PRICES), int'(idx), PRICE_W));

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < N_ITEMS; i++) begin
      if (sel[i]) sel_idx = IDX_W'(i);
    end
  end

  always_comb begin
    case ({c1, c2})
      2'b10:   coin_val = COIN1_VAL;
      2'b01:   coin_val = COIN2_VAL;
      default: coin_val = 2'd0;
    endcase
  end

`ifdef VEND_TIMEOUT_EN
  localparam int                TMO_W    = $clog2(TIMEOUT + 1);
  // Loaded two short so the refund pulse lands TIMEOUT cycles after the last coin.
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT - 2);

  logic [TMO_W-1:0] tmo_cnt;

  assign tmo_expired = (state == COLLECT) && (tmo_cnt == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt <= '0;
    end else if (state == CHECK || coin_acc) begin
      tmo_cnt <= TMO_LOAD;
    end else if (state == COLLECT && tmo_cnt != '0) begin
      tmo_cnt <= tmo_cnt - 1'b1;
    end
  end
`else
  // Constant 0: without the counter TIMEOUT has no effect.
  assign tmo_expired = (TIMEOUT < 0);
`endif

  always_comb begin
    state_nxt  = state;
    credit_clr = 1'b0;
    coin_acc   = 1'b0;
    case (state)
      IDLE: begin
        if (sel_one) state_nxt = CHECK;
      end
      CHECK: begin
        credit_clr = 1'b1;
        state_nxt  = item_available[idx] ? COLLECT : IDLE;
      end
      COLLECT: begin
        if (cnl || (|sel))    state_nxt = REFUND;
        else if (at_price)    state_nxt = VEND;
        else if (tmo_expired) state_nxt = REFUND;
        else                  coin_acc  = c1 ^ c2;
      end
      VEND, REFUND: begin
        credit_clr = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  vend_credit_acc #(.CREDIT_W(CREDIT_W)) u_credit (
    .clk      (clk),
    .rst      (rst),
    .clr      (credit_clr),
    .add_en   (coin_acc),
    .add_val  (coin_val),
    .price    (price),
    .credit   (credit),
    .at_price (at_price)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && sel_one) idx <= sel_idx;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pdt      <= 1'b0;
      pdt_item <= '0;
      cng      <= '0;
      rtn      <= '0;
      rtn_vld  <= 1'b0;
      sold_out <= 1'b0;
      busy     <= 1'b0;
    end else begin
      pdt      <= (state == VEND);
      pdt_item <= (state == VEND) ? idx : '0;
      cng      <= (state == VEND) ? (credit - price) : '0;
      rtn_vld  <= (state == REFUND);
      rtn      <= (state == REFUND) ? credit : '0;
      sold_out <= (state == CHECK) && !item_available[idx];
      busy     <= (state != IDLE);
    end
  end

endmodule

// File: tb/tb_vending_machine_param.sv
// Scoreboard bench for vending_machine_param: expected pulses are queued as stimulus
// is driven and matched (kind, value, item, cycle) as the DUT emits them.
module tb_vending_machine_param;

  localparam int KIND_VEND = 0;
  localparam int KIND_RTN  = 1;
  localparam int KIND_SOLD = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       c1 = 1'b0, c2 = 1'b0, cnl = 1'b0;
  logic [3:0] sel = '0;
  logic [3:0] item_available = 4'b1111;
  logic       pdt, rtn_vld, sold_out, busy;
  logic [1:0] pdt_item;
  logic [3:0] cng, rtn;

  typedef struct {
    int kind;
    int item;
    int val;
    int cyc;
  } ev_t;

  ev_t sb[$];
  ev_t e;
  int  cyc = 0;
  int  n_cmp = 0;
  int  n_bad = 0;

  vending_machine_param #(
    .N_ITEMS (4),
    .PRICE_W (4),
    .PRICES  ({4'd6, 4'd5, 4'd4, 4'd3}),
    .CREDIT_W(4),
    .TIMEOUT (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .c1            (c1),
    .c2            (c2),
    .sel           (sel),
    .cnl           (cnl),
    .item_available(item_available),
    .pdt           (pdt),
    .pdt_item      (pdt_item),
    .cng           (cng),
    .rtn           (rtn),
    .rtn_vld       (rtn_vld),
    .sold_out      (sold_out),
    .busy          (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Credit can never reach all-ones with the legal price table.
  always @(posedge clk) begin
    if (rst) assert (dut.credit !== 4'hF) else $error("FAIL credit_saturation credit=%0d", dut.credit);
  end

  // Monitor: every output pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (pdt || rtn_vld || sold_out) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_event cyc=%0d pdt=%0b rtn_vld=%0b sold_out=%0b", cyc, pdt, rtn_vld, sold_out);
      end else begin
        e = sb.pop_front();
        if ((pdt ? KIND_VEND : rtn_vld ? KIND_RTN : KIND_SOLD) !== e.kind || cyc !== e.cyc) begin
          n_bad++;
          $display("FAIL event_kind_time got pdt=%0b rtn_vld=%0b sold_out=%0b at cyc %0d, want kind %0d at cyc %0d",
                   pdt, rtn_vld, sold_out, cyc, e.kind, e.cyc);
        end
        n_cmp++;
        if (e.kind == KIND_VEND && (int'(cng) !== e.val || int'(pdt_item) !== e.item)) begin
          n_bad++;
          $display("FAIL vend_value got cng=%0d item=%0d, want cng=%0d item=%0d", cng, pdt_item, e.val, e.item);
        end else if (e.kind == KIND_RTN && int'(rtn) !== e.val) begin
          n_bad++;
          $display("FAIL refund_value got rtn=%0d, want %0d", rtn, e.val);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_sel(input int i);
    sel = 4'b0001 << i;
    step();
    sel = '0;
  endtask

  task automatic coin(input logic v1, input logic v2);
    c1 = v1;
    c2 = v2;
    step();
    c1 = 1'b0;
    c2 = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout %0d expected events never seen, want 0", sb.size());
      sb.delete();
    end
    step();
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++;
    if ({pdt, pdt_item, cng, rtn, rtn_vld, sold_out, busy} !== 15'd0) begin
      n_bad++;
      $display("FAIL reset_outputs got pdt=%0b item=%0d cng=%0d rtn=%0d rtn_vld=%0b sold_out=%0b busy=%0b, want all 0",
               pdt, pdt_item, cng, rtn, rtn_vld, sold_out, busy);
    end
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_vend_basic();
    do_sel(0);
    step();
    coin(1'b0, 1'b1);
    coin(1'b0, 1'b1);
    sb.push_back('{KIND_VEND, 0, 1, cyc + 2});
    repeat (3) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL busy_with_pdt got %0b, want 1", busy);
    end
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL busy_after_pdt got %0b, want 0", busy);
    end
    wait_drain();
  endtask

  task automatic test_back_to_back();
    do_sel(3);
    step();
    coin(1'b0, 1'b1);
    coin(1'b0, 1'b1);
    coin(1'b1, 1'b0);
    coin(1'b0, 1'b1);
    sb.push_back('{KIND_VEND, 3, 1, cyc + 2});
    step();
    step();
    do_sel(1);
    step();
    coin(1'b0, 1'b1);
    coin(1'b0, 1'b1);
    sb.push_back('{KIND_VEND, 1, 0, cyc + 2});
    wait_drain();
  endtask

  task automatic test_cancel();
    do_sel(1);
    step();
    coin(1'b0, 1'b1);
    coin(1'b1, 1'b0);
    cnl = 1'b1;
    c1  = 1'b1;
    step();
    cnl = 1'b0;
    c1  = 1'b0;
    sb.push_back('{KIND_RTN, 0, 3, cyc + 1});
    wait_drain();
  endtask

  task automatic test_sold_out();
    item_available = 4'b1011;
    do_sel(2);
    sb.push_back('{KIND_SOLD, 0, 0, cyc + 1});
    step();
    coin(1'b0, 1'b1);
    coin(1'b0, 1'b1);
    coin(1'b1, 1'b0);
    wait_drain();
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL sold_out_idle busy=%0b, want 0", busy);
    end
    item_available = 4'b1111;
    step();
  endtask

  task automatic test_sel_refund();
    do_sel(0);
    step();
    coin(1'b0, 1'b1);
    sel = 4'b0010;
    step();
    sel = '0;
    sb.push_back('{KIND_RTN, 0, 2, cyc + 1});
    wait_drain();
    repeat (2) step();
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL sel_refund_idle busy=%0b, want 0", busy);
    end
    step();
  endtask

  task automatic test_both_coins();
    do_sel(2);
    step();
    coin(1'b1, 1'b1);
    coin(1'b0, 1'b1);
    coin(1'b0, 1'b1);
    coin(1'b1, 1'b0);
    sb.push_back('{KIND_VEND, 2, 0, cyc + 2});
    wait_drain();
  endtask

  task automatic test_reset_mid();
    do_sel(3);
    step();
    coin(1'b0, 1'b1);
    coin(1'b0, 1'b1);
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL busy_collect got %0b, want 1", busy);
    end
    #1 rst = 1'b0;
    #1;
    n_cmp++;
    if ({pdt, pdt_item, cng, rtn, rtn_vld, sold_out, busy} !== 15'd0) begin
      n_bad++;
      $display("FAIL reset_mid_outputs got pdt=%0b item=%0d cng=%0d rtn=%0d rtn_vld=%0b sold_out=%0b busy=%0b, want all 0",
               pdt, pdt_item, cng, rtn, rtn_vld, sold_out, busy);
    end
    step();
    step();
    rst = 1'b1;
    step();
    // Leftover credit would vend early with change; a clean start gives exactly 3.
    do_sel(0);
    step();
    coin(1'b1, 1'b0);
    coin(1'b0, 1'b1);
    sb.push_back('{KIND_VEND, 0, 0, cyc + 2});
    wait_drain();
  endtask

`ifdef VEND_TIMEOUT_EN
  task automatic test_timeout();
    do_sel(0);
    step();
    coin(1'b1, 1'b0);
    sb.push_back('{KIND_RTN, 0, 1, cyc + 8});
    wait_drain();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_vend_basic();
    test_back_to_back();
    test_cancel();
    test_sold_out();
    test_sel_refund();
    test_both_coins();
    test_reset_mid();
`ifdef VEND_TIMEOUT_EN
    test_timeout();
`endif
    repeat (4) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
